// File: rtl/shift_flag_stage.sv
// shift_flag_stage
//
// Registered output stage for a 16-bit shifter. It accepts an operation
// (function code, shift amount, the unshifted operand and the shifter's
// combinational result), computes the {S,Z,C,V} condition code at acceptance,
// and presents the result and code on a valid/ready output. A main register
// plus one skid register give full throughput while keeping in_ready a
// pure flop output. The architectural SZCV register (flags) loads the code of
// every legal operation as it leaves the stage.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   upstream presents an operation
//   in_ready   out  1   stage can accept (skid register empty), registered
//   fcode      in   4   SLL 1000, SLR 1001 (rotate left), SRL 1010, SRA 1011
//   shift      in   5   shift amount, bit 4 ignored
//   operand    in   16  unshifted source operand
//   sh_result  in   16  shifter result for fcode/shift/operand
//   out_valid  out  1   out_result/out_code valid
//   out_ready  in   1   downstream accepts the output
//   out_result out  16  registered result
//   out_code   out  4   registered condition code {S,Z,C,V}
//   flags      out  4   architectural SZCV register
//
// Parameter V_MODE: 0 -> V always 0; 1 -> V set on SLL when the sign changes.

module shift_flag_stage #(
    parameter int unsigned V_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  fcode,
    input  logic [4:0]  shift,
    input  logic [15:0] operand,
    input  logic [15:0] sh_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [3:0]  out_code,
    output logic [3:0]  flags
);

    // Condition code of the operation presented this cycle
    logic [3:0]  n;
    logic        new_legal;
    logic [15:0] new_result;
    logic [3:0]  new_code;
    logic [4:0]  sll_tmp;
    logic [3:0]  sll_idx;
    logic [3:0]  srl_idx;
    logic        c_bit;
    logic        v_bit;

    always_comb begin
        n          = shift[3:0];
        new_legal  = (fcode[3:2] == 2'b10);
        new_result = new_legal ? sh_result : operand;
        // Last bit shifted out: operand[16-n] for left, operand[n-1] for right.
        // Both indices are only used when n != 0, so they stay within 1..15 / 0..14.
        sll_tmp    = 5'd16 - {1'b0, n};
        sll_idx    = sll_tmp[3:0];
        srl_idx    = n - 4'd1;
        c_bit      = 1'b0;
        if (new_legal && (n != 4'd0)) begin
            case (fcode[1:0])
                2'b00:   c_bit = operand[sll_idx];
                2'b01:   c_bit = sh_result[0];  // rotate: bit wrapped into LSB
                default: c_bit = operand[srl_idx];
            endcase
        end
        v_bit    = (V_MODE == 1) && new_legal && (fcode[1:0] == 2'b00) &&
                   (sh_result[15] != operand[15]);
        new_code = {new_result[15], (new_result == 16'h0000), c_bit, v_bit};
    end

    // Main and skid registers
    logic        main_valid_q, main_valid_d;
    logic [15:0] main_result_q, main_result_d;
    logic [3:0]  main_code_q, main_code_d;
    logic        main_legal_q, main_legal_d;
    logic        skid_valid_q, skid_valid_d;
    logic [15:0] skid_result_q, skid_result_d;
    logic [3:0]  skid_code_q, skid_code_d;
    logic        skid_legal_q, skid_legal_d;
    logic        in_ready_q, in_ready_d;
    logic [3:0]  flags_q, flags_d;
    logic        in_hs;
    logic        out_hs;

    always_comb begin
        main_valid_d  = main_valid_q;
        main_result_d = main_result_q;
        main_code_d   = main_code_q;
        main_legal_d  = main_legal_q;
        skid_valid_d  = skid_valid_q;
        skid_result_d = skid_result_q;
        skid_code_d   = skid_code_q;
        skid_legal_d  = skid_legal_q;

        in_hs  = in_valid && in_ready_q;
        out_hs = main_valid_q && out_ready;

        if (!main_valid_q || out_hs) begin
            // Main is free at this edge. in_ready is low whenever the skid is
            // full, so a skid transfer and a new acceptance never coincide.
            if (skid_valid_q) begin
                main_valid_d  = 1'b1;
                main_result_d = skid_result_q;
                main_code_d   = skid_code_q;
                main_legal_d  = skid_legal_q;
                skid_valid_d  = 1'b0;
            end else begin
                main_valid_d = in_hs;
                if (in_hs) begin
                    main_result_d = new_result;
                    main_code_d   = new_code;
                    main_legal_d  = new_legal;
                end
            end
        end else if (in_hs) begin
            // Main is stalled: park the new operation in the skid register
            skid_valid_d  = 1'b1;
            skid_result_d = new_result;
            skid_code_d   = new_code;
            skid_legal_d  = new_legal;
        end

        flags_d    = (out_hs && main_legal_q) ? main_code_q : flags_q;
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q  <= 1'b0;
            main_result_q <= 16'h0000;
            main_code_q   <= 4'b0000;
            main_legal_q  <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_result_q <= 16'h0000;
            skid_code_q   <= 4'b0000;
            skid_legal_q  <= 1'b0;
            in_ready_q    <= 1'b0;
            flags_q       <= 4'b0000;
        end else begin
            main_valid_q  <= main_valid_d;
            main_result_q <= main_result_d;
            main_code_q   <= main_code_d;
            main_legal_q  <= main_legal_d;
            skid_valid_q  <= skid_valid_d;
            skid_result_q <= skid_result_d;
            skid_code_q   <= skid_code_d;
            skid_legal_q  <= skid_legal_d;
            in_ready_q    <= in_ready_d;
            flags_q       <= flags_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid_q;
    assign out_result = main_result_q;
    assign out_code   = main_code_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_shift_flag_stage.sv
// Testbench for shift_flag_stage: directed vector table, hand-written
// stall/back-to-back/reset sequences, then randomized traffic checked against
// a queue-based reference model. Two instances run in lockstep on the same
// inputs, one with V_MODE 0 and one with V_MODE 1.

module tb_shift_flag_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  fcode;
    logic [4:0]  shift;
    logic [15:0] operand;
    logic [15:0] sh_result;
    logic        out_ready;

    logic        in_ready0, out_valid0;
    logic [15:0] out_result0;
    logic [3:0]  out_code0, flags0;
    logic        in_ready1, out_valid1;
    logic [15:0] out_result1;
    logic [3:0]  out_code1, flags1;

    shift_flag_stage #(.V_MODE(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .fcode      (fcode),
        .shift      (shift),
        .operand    (operand),
        .sh_result  (sh_result),
        .out_valid  (out_valid0),
        .out_ready  (out_ready),
        .out_result (out_result0),
        .out_code   (out_code0),
        .flags      (flags0)
    );

    shift_flag_stage #(.V_MODE(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready1),
        .fcode      (fcode),
        .shift      (shift),
        .operand    (operand),
        .sh_result  (sh_result),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .out_result (out_result1),
        .out_code   (out_code1),
        .flags      (flags1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] result;
        logic [3:0]  code0;
        logic [3:0]  code1;
        logic        legal;
    } entry_t;

    entry_t      q[$];
    logic [3:0]  m_flags0;
    logic [3:0]  m_flags1;
    logic        m_in_ready;
    logic        m_after_reset;

    function automatic logic [3:0] ref_code(input logic [3:0] fc, input logic [4:0] sh,
                                            input logic [15:0] op, input logic [15:0] shr,
                                            input int vmode);
        int   n;
        int   opi;
        int   f;
        logic legal;
        logic [15:0] src;
        logic c;
        logic v;
        f     = int'(fc);
        n     = int'(sh) % 16;
        opi   = int'(op);
        legal = (f >= 8) && (f <= 11);
        src   = legal ? shr : op;
        c     = 1'b0;
        if (legal && n != 0) begin
            if (f == 8)       c = ((opi >> (16 - n)) & 1) != 0;
            else if (f == 9)  c = shr[0];
            else              c = ((opi >> (n - 1)) & 1) != 0;
        end
        v = (vmode == 1) && (f == 8) && (shr[15] != op[15]);
        return {src[15], src == 16'h0000, c, v};
    endfunction

    function automatic logic [15:0] ref_shift(input logic [3:0] fc, input logic [4:0] sh,
                                              input logic [15:0] op);
        int n;
        logic [31:0] dbl;
        n   = int'(sh) % 16;
        dbl = {op, op} << n;
        case (fc)
            4'b1000: return op << n;
            4'b1001: return dbl[31:16];
            4'b1010: return op >> n;
            4'b1011: return 16'($signed(op) >>> n);
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid0}, {31'd0, q.size() > 0});
        chk("out_valid_v1", {31'd0, out_valid1}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, in_ready0}, {31'd0, m_in_ready});
        chk("in_ready_v1", {31'd0, in_ready1}, {31'd0, m_in_ready});
        chk("flags", {28'd0, flags0}, {28'd0, m_flags0});
        chk("flags_v1", {28'd0, flags1}, {28'd0, m_flags1});
        if (q.size() > 0) begin
            chk("out_result", {16'd0, out_result0}, {16'd0, q[0].result});
            chk("out_result_v1", {16'd0, out_result1}, {16'd0, q[0].result});
            chk("out_code", {28'd0, out_code0}, {28'd0, q[0].code0});
            chk("out_code_v1", {28'd0, out_code1}, {28'd0, q[0].code1});
        end else if (m_after_reset) begin
            chk("reset_result", {16'd0, out_result0}, 32'd0);
            chk("reset_code", {28'd0, out_code0}, 32'd0);
        end
    endtask

    // One clock: drive at negedge, update the model at posedge, check at negedge.
    task automatic step(input logic iv, input logic [3:0] fc, input logic [4:0] sh,
                        input logic [15:0] op, input logic [15:0] shr,
                        input logic ordy, input logic r);
        logic   ihs;
        logic   ohs;
        entry_t e;
        in_valid  = iv;
        fcode     = fc;
        shift     = sh;
        operand   = op;
        sh_result = shr;
        out_ready = ordy;
        rst       = r;
        ihs = iv && m_in_ready;
        ohs = (q.size() > 0) && ordy;
        e.result = ((fc >= 4'd8) && (fc <= 4'd11)) ? shr : op;
        e.code0  = ref_code(fc, sh, op, shr, 0);
        e.code1  = ref_code(fc, sh, op, shr, 1);
        e.legal  = (fc >= 4'd8) && (fc <= 4'd11);
        @(posedge clk);
        if (r) begin
            q.delete();
            m_flags0      = 4'b0000;
            m_flags1      = 4'b0000;
            m_in_ready    = 1'b0;
            m_after_reset = 1'b1;
        end else begin
            if (ohs) begin
                if (q[0].legal) begin
                    m_flags0 = q[0].code0;
                    m_flags1 = q[0].code1;
                end
                void'(q.pop_front());
            end
            if (ihs) q.push_back(e);
            m_in_ready    = (q.size() < 2);
            m_after_reset = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'd0, 5'd0, 16'h0, 16'h0, ordy, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  fc;
        logic [4:0]  sh;
        logic [15:0] op;
        logic [15:0] shr;
        logic [15:0] exp_result;
        logic [3:0]  exp_code0;
        logic [3:0]  exp_code1;
        logic [3:0]  exp_flags0;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'b1000, 5'd1,  16'h8001, 16'h0002, 16'h0002, 4'b0010, 4'b0011, 4'b0010};
        vecs[1] = '{4'b1010, 5'd1,  16'h0001, 16'h0000, 16'h0000, 4'b0110, 4'b0110, 4'b0110};
        vecs[2] = '{4'b1011, 5'd15, 16'h8000, 16'hFFFF, 16'hFFFF, 4'b1000, 4'b1000, 4'b1000};
        vecs[3] = '{4'b0000, 5'd0,  16'h0000, 16'h1234, 16'h0000, 4'b0100, 4'b0100, 4'b1000};
        vecs[4] = '{4'b1001, 5'd4,  16'h1234, 16'h2341, 16'h2341, 4'b0010, 4'b0010, 4'b0010};
        vecs[5] = '{4'b1100, 5'd3,  16'h8000, 16'h0000, 16'h8000, 4'b1000, 4'b1000, 4'b0010};
        vecs[6] = '{4'b1000, 5'h10, 16'h8000, 16'h8000, 16'h8000, 4'b1000, 4'b1000, 4'b1000};
        vecs[7] = '{4'b1000, 5'd4,  16'h1F00, 16'hF000, 16'hF000, 4'b1010, 4'b1011, 4'b1010};
        vecs[8] = '{4'b1011, 5'd3,  16'h0004, 16'h0000, 16'h0000, 4'b0110, 4'b0110, 4'b0110};

        in_valid = 1'b0; fcode = 4'd0; shift = 5'd0; operand = 16'h0;
        sh_result = 16'h0; out_ready = 1'b0; rst = 1'b1;
        q.delete();
        m_flags0 = 4'b0; m_flags1 = 4'b0; m_in_ready = 1'b0; m_after_reset = 1'b1;

        @(negedge clk);
        step(1'b0, 4'd0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("reset_in_ready_low", {31'd0, in_ready0}, 32'd0);
        idle(1'b0);
        chk("in_ready_after_reset", {31'd0, in_ready0}, 32'd1);

        // Table: one op at a time, checked against hand-derived constants
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].fc, vecs[i].sh, vecs[i].op, vecs[i].shr, 1'b1, 1'b0);
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid0}, 32'd1);
            chk($sformatf("vec%0d_result", i), {16'd0, out_result0}, {16'd0, vecs[i].exp_result});
            chk($sformatf("vec%0d_code", i), {28'd0, out_code0}, {28'd0, vecs[i].exp_code0});
            chk($sformatf("vec%0d_code_v1", i), {28'd0, out_code1}, {28'd0, vecs[i].exp_code1});
            idle(1'b1);
            chk($sformatf("vec%0d_flags", i), {28'd0, flags0}, {28'd0, vecs[i].exp_flags0});
        end

        // Stall: A into main, B into skid, C held off until release
        step(1'b1, 4'b1010, 5'd0, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0);
        step(1'b1, 4'b1010, 5'd0, 16'hBBBB, 16'hBBBB, 1'b0, 1'b0);
        chk("stall_in_ready_low", {31'd0, in_ready0}, 32'd0);
        chk("stall_main_a", {16'd0, out_result0}, 32'h0000AAAA);
        step(1'b1, 4'b1010, 5'd0, 16'hCCCC, 16'hCCCC, 1'b0, 1'b0);
        chk("stall_hold_a", {16'd0, out_result0}, 32'h0000AAAA);
        step(1'b1, 4'b1010, 5'd0, 16'hCCCC, 16'hCCCC, 1'b1, 1'b0);
        chk("release_b", {16'd0, out_result0}, 32'h0000BBBB);
        chk("release_in_ready", {31'd0, in_ready0}, 32'd1);
        step(1'b1, 4'b1010, 5'd0, 16'hCCCC, 16'hCCCC, 1'b1, 1'b0);
        chk("release_c", {16'd0, out_result0}, 32'h0000CCCC);
        idle(1'b1);
        chk("release_empty", {31'd0, out_valid0}, 32'd0);

        // Back-to-back: 8 ops, 8 consecutive valid cycles
        begin
            int nvalid;
            nvalid = 0;
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 4'b1000, 5'(i), 16'(i * 16'h0101 + 1), 16'((i * 16'h0101 + 1) << i),
                     1'b1, 1'b0);
                if (out_valid0) nvalid++;
            end
            idle(1'b1);
            chk("b2b_valid_cycles", nvalid, 32'd8);
            chk("b2b_then_empty", {31'd0, out_valid0}, 32'd0);
        end

        // Reset with both registers full
        step(1'b1, 4'b1011, 5'd2, 16'h8004, 16'hE001, 1'b0, 1'b0);
        step(1'b1, 4'b1000, 5'd1, 16'h4000, 16'h8000, 1'b0, 1'b0);
        chk("full_before_reset", {31'd0, in_ready0}, 32'd0);
        step(1'b1, 4'b1000, 5'd1, 16'h4000, 16'h8000, 1'b1, 1'b1);
        chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_flags", {28'd0, flags0}, 32'd0);
        idle(1'b1);
        chk("rst_in_ready_back", {31'd0, in_ready0}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [3:0]  fc;
            logic [4:0]  sh;
            logic [15:0] op;
            fc = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(8, 11));
            sh = 5'($urandom);
            op = 16'($urandom);
            if ($urandom_range(0, 3) == 0) op = 16'h8000 >> $urandom_range(0, 15);
            step(1'($urandom_range(0, 3) != 0), fc, sh, op, ref_shift(fc, sh, op),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
